// File: rtl/ln_vec_packer_pkg.sv
// Shared types and constants for the layernorm input packer.
// Element geometry, FSM state encoding and the wide vector type.
package ln_pkg;

    localparam int LN_ELEM_WIDTH = 8;
    localparam int LN_VEC_LEN    = 768;
    localparam int LN_BEAT_ELEMS = 8;
    localparam int LN_MIN_GAP    = 16;

    localparam int LN_BEAT_W = LN_ELEM_WIDTH * LN_BEAT_ELEMS;
    localparam int LN_VEC_W  = LN_ELEM_WIDTH * LN_VEC_LEN;

    typedef logic [LN_VEC_W-1:0] ln_vec_t;

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ln_vec_packer_if.sv
// Narrow beat stream feeding the packer.
// Source drives payload/valid/last, the packer answers with ready.
interface ln_vec_packer_if
    import ln_pkg::*;
#(
    parameter int W = LN_BEAT_W
);

    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/ln_vec_packer_throttle.sv
// Gap counter that spaces successive issues by MIN_GAP cycles.
// Starts saturated so the first issue after reset is never held.
module issue_throttle
    import ln_pkg::*;
#(
    parameter int MIN_GAP = LN_MIN_GAP
) (
    input  logic clk_p,
    input  logic rst_n,
    input  logic fire,
    output logic fire_en
);

    localparam int GW = cnt_width(MIN_GAP + 1);

    logic [GW-1:0] gap_cnt;

    assign fire_en = (gap_cnt >= GW'(MIN_GAP));

    // Restart at one on an issue, otherwise count up and saturate.
    always_ff @(posedge clk_p) begin
        if (rst_n) begin
            gap_cnt <= GW'(MIN_GAP);
        end else if (fire) begin
            gap_cnt <= GW'(1);
        end else if (gap_cnt < GW'(MIN_GAP)) begin
            gap_cnt <= gap_cnt + GW'(1);
        end
    end

endmodule

// File: rtl/ln_vec_packer.sv
// Packs a narrow beat stream into one wide layernorm vector.
// Issues each vector as a single-cycle active-low pulse, rate limited.
module ln_vec_packer
    import ln_pkg::*;
#(
    parameter int ELEM_WIDTH = LN_ELEM_WIDTH,
    parameter int VEC_LEN    = LN_VEC_LEN,
    parameter int BEAT_ELEMS = LN_BEAT_ELEMS,
    parameter int MIN_GAP    = LN_MIN_GAP
) (
    input  logic                          clk_p,
    input  logic                          rst_n,
    ln_vec_packer_if.slave                in_bus,
    output logic [ELEM_WIDTH*VEC_LEN-1:0] out_data,
    output logic                          out_valid_n,
    output logic                          err_len,
    input  logic                          err_clr,
    output logic [15:0]                   vec_cnt
);

    localparam int W     = ELEM_WIDTH * BEAT_ELEMS;
    localparam int BEATS = VEC_LEN / BEAT_ELEMS;
    localparam int CNT_W = cnt_width(BEATS);

    state_t                    state;
    logic [CNT_W-1:0]          beat_cnt;
    logic [BEATS-1:0][W-1:0]   fill_buf;

    logic accept;
    logic last_slot;
    logic set_err;
    logic gap_ok;
    logic fire;

    assign in_bus.in_ready = (state == FILL) & ~rst_n;

    assign accept    = in_bus.in_valid & in_bus.in_ready;
    assign last_slot = (beat_cnt == CNT_W'(BEATS - 1));
    assign set_err   = accept & (last_slot ^ in_bus.in_last);
    assign fire      = (state == ISSUE) & gap_ok;

    issue_throttle #(
        .MIN_GAP (MIN_GAP)
    ) u_throttle (
        .clk_p   (clk_p),
        .rst_n   (rst_n),
        .fire    (fire),
        .fire_en (gap_ok)
    );

    // Land each accepted beat in its slot; contents need no reset.
    always_ff @(posedge clk_p) begin
        if (accept) begin
            fill_buf[beat_cnt] <= in_bus.in_data;
        end
    end

    // Fill/issue sequencing, output register, error flag and counter.
    always_ff @(posedge clk_p) begin
        if (rst_n) begin
            state       <= FILL;
            beat_cnt    <= '0;
            out_data    <= '0;
            out_valid_n <= 1'b1;
            err_len     <= 1'b0;
            vec_cnt     <= '0;
        end else begin
            out_valid_n <= 1'b1;
            if (err_clr) begin
                err_len <= 1'b0;
            end
            if (set_err) begin
                err_len <= 1'b1;
            end
            unique case (state)
                FILL: begin
                    if (accept) begin
                        if (last_slot) begin
                            beat_cnt <= '0;
                            state    <= ISSUE;
                        end else if (in_bus.in_last) begin
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (gap_ok) begin
                        out_data    <= fill_buf;
                        out_valid_n <= 1'b0;
                        vec_cnt     <= vec_cnt + 16'd1;
                        state       <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ln_vec_packer.sv
// Directed bench for ln_vec_packer with a 200-cycle issue gap.
// Each scenario task drives beats and checks pulses, data and flags.
module tb_ln_vec_packer;

    import ln_pkg::*;

    localparam int GAP = 200;
    localparam int VW  = 6144;

    logic          clk_p = 1'b0;
    logic          rst_n;
    logic          err_clr;
    logic [VW-1:0] out_data;
    logic          out_valid_n;
    logic          err_len;
    logic [15:0]   vec_cnt;

    ln_vec_packer_if #(.W(64)) bus ();

    ln_vec_packer #(
        .ELEM_WIDTH (8),
        .VEC_LEN    (768),
        .BEAT_ELEMS (8),
        .MIN_GAP    (GAP)
    ) dut (
        .clk_p       (clk_p),
        .rst_n       (rst_n),
        .in_bus      (bus),
        .out_data    (out_data),
        .out_valid_n (out_valid_n),
        .err_len     (err_len),
        .err_clr     (err_clr),
        .vec_cnt     (vec_cnt)
    );

    always #5 clk_p = ~clk_p;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            long_pulses = 0;
    bit            prev_low = 1'b0;
    int            pulse_q[$];
    logic [VW-1:0] data_q[$];
    int            last_accept = 0;
    int            rst_edge = 0;
    logic [VW-1:0] exp_vec;

    // Count edges and record every low sample of out_valid_n.
    always begin
        @(posedge clk_p);
        cyc++;
        #1;
        if (out_valid_n === 1'b0) begin
            if (prev_low) long_pulses++;
            pulse_q.push_back(cyc);
            data_q.push_back(out_data);
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
        end
    end

    function automatic logic [63:0] ramp_beat(input int k, input int off);
        logic [63:0] b;
        for (int i = 0; i < 8; i++) b[i*8 +: 8] = 8'(k*8 + i + off);
        return b;
    endfunction

    function automatic int first_diff(input logic [VW-1:0] a,
                                      input logic [VW-1:0] b);
        for (int k = 0; k < 96; k++)
            if (a[k*64 +: 64] !== b[k*64 +: 64]) return k;
        return 0;
    endfunction

    function automatic int exp_edge(input int n0, input int acc);
        int e;
        e = acc + 1;
        if (n0 > 0 && pulse_q[n0-1] > rst_edge && pulse_q[n0-1] + GAP > e)
            e = pulse_q[n0-1] + GAP;
        return e;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic l,
                             input int idle);
        repeat (idle) begin
            @(negedge clk_p);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
        @(negedge clk_p);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int n = 0; n < 600 && bus.in_ready !== 1'b1; n++)
            @(negedge clk_p);
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: in_ready=%b want 1",
                     bus.in_ready);
        end
        last_accept = cyc + 1;
        @(posedge clk_p);
    endtask

    task automatic send_vec(input int off, input int nbeats,
                            input int last_idx, input bit rnd);
        logic [63:0] d;
        for (int k = 0; k < nbeats; k++) begin
            d = rnd ? {$urandom, $urandom} : ramp_beat(k, off);
            exp_vec[k*64 +: 64] = d;
            send_beat(d, k == last_idx,
                      rnd ? int'($urandom_range(0, 1)) : 0);
        end
        @(negedge clk_p);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_pulse(input int n0, output bit ok);
        for (int n = 0; n < 600 && pulse_q.size() <= n0; n++)
            @(negedge clk_p);
        ok = (pulse_q.size() > n0);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pulse_timeout: pulses=%0d want >%0d",
                     pulse_q.size(), n0);
        end
    endtask

    task automatic chk_pulse(input string nm, input int n0);
        int e;
        int k;
        e = exp_edge(n0, last_accept);
        checks++;
        if (pulse_q[n0] !== e) begin
            errors++;
            $display("FAIL %s_edge: got %0d want %0d", nm, pulse_q[n0], e);
        end
        checks++;
        if (data_q[n0] !== exp_vec) begin
            errors++;
            k = first_diff(data_q[n0], exp_vec);
            $display("FAIL %s_data: beat %0d got %h want %h", nm, k,
                     data_q[n0][k*64 +: 64], exp_vec[k*64 +: 64]);
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b1;
        err_clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk_p);
        checks++;
        if (out_valid_n !== 1'b1) begin
            errors++;
            $display("FAIL rst_valid_n: got %b want 1", out_valid_n);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL rst_data: low word %h want 0", out_data[63:0]);
        end
        checks++;
        if (vec_cnt !== 16'd0 || err_len !== 1'b0) begin
            errors++;
            $display("FAIL rst_cnt_err: vec_cnt=%0d err=%b want 0/0",
                     vec_cnt, err_len);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: got %b want 0", bus.in_ready);
        end
        rst_n = 1'b0;
        rst_edge = cyc;
        @(negedge clk_p);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single;
        int n0;
        bit ok;
        int bad;
        n0 = pulse_q.size();
        send_vec(0, 96, 95, 1'b0);
        wait_pulse(n0, ok);
        if (ok) begin
            chk_pulse("single", n0);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_ready: got %b want 1", bus.in_ready);
            end
        end
        bad = 0;
        for (int j = 0; j < 768; j++)
            if (out_data[j*8 +: 8] !== 8'(j)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_bytes: %0d bad bytes want 0", bad);
        end
        checks++;
        if (vec_cnt !== 16'd1 || err_len !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt_err: vec_cnt=%0d err=%b want 1/0",
                     vec_cnt, err_len);
        end
        @(negedge clk_p);
        checks++;
        if (out_valid_n !== 1'b1 || long_pulses != 0) begin
            errors++;
            $display("FAIL single_width: valid_n=%b long=%0d want 1/0",
                     out_valid_n, long_pulses);
        end
    endtask

    task automatic test_back_to_back;
        int n0;
        int pa;
        bit ok;
        logic [VW-1:0] exp_a;
        repeat (210) @(negedge clk_p);
        n0 = pulse_q.size();
        send_vec(1, 96, 95, 1'b0);
        exp_a = exp_vec;
        send_vec(2, 96, 95, 1'b0);
        wait_pulse(n0, ok);
        pa = ok ? pulse_q[n0] : cyc;
        for (int n = 0; n < 400 && cyc < pa + 150; n++) @(negedge clk_p);
        checks++;
        if (bus.in_ready !== 1'b0 || out_valid_n !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wait: ready=%b valid_n=%b want 0/1",
                     bus.in_ready, out_valid_n);
        end
        checks++;
        if (out_data !== exp_a) begin
            errors++;
            $display("FAIL b2b_hold: beat0 %h want %h",
                     out_data[63:0], exp_a[63:0]);
        end
        wait_pulse(n0 + 1, ok);
        if (ok) begin
            checks++;
            if (pulse_q[n0+1] - pa !== GAP) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d want %0d",
                         pulse_q[n0+1] - pa, GAP);
            end
            chk_pulse("b2b", n0 + 1);
        end
    endtask

    task automatic test_early_last;
        int n0;
        bit ok;
        repeat (210) @(negedge clk_p);
        n0 = pulse_q.size();
        send_vec(3, 41, 40, 1'b0);
        repeat (20) @(negedge clk_p);
        checks++;
        if (pulse_q.size() !== n0) begin
            errors++;
            $display("FAIL early_no_pulse: pulses=%0d want %0d",
                     pulse_q.size(), n0);
        end
        checks++;
        if (err_len !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL early_err: err=%b ready=%b want 1/1",
                     err_len, bus.in_ready);
        end
        send_vec(64, 96, 95, 1'b0);
        wait_pulse(n0, ok);
        if (ok) chk_pulse("early_next", n0);
        checks++;
        if (out_data[63:0] !== 64'h4746454443424140) begin
            errors++;
            $display("FAIL early_beat0: got %h want 4746454443424140",
                     out_data[63:0]);
        end
        checks++;
        if (vec_cnt !== 16'd4 || err_len !== 1'b1) begin
            errors++;
            $display("FAIL early_cnt: vec_cnt=%0d err=%b want 4/1",
                     vec_cnt, err_len);
        end
    endtask

    task automatic test_len_err;
        int n0;
        bit ok;
        @(negedge clk_p);
        err_clr = 1'b1;
        @(negedge clk_p);
        err_clr = 1'b0;
        checks++;
        if (err_len !== 1'b0) begin
            errors++;
            $display("FAIL clr_first: err=%b want 0", err_len);
        end
        n0 = pulse_q.size();
        send_vec(5, 96, -1, 1'b0);
        wait_pulse(n0, ok);
        if (ok) chk_pulse("nolast", n0);
        checks++;
        if (err_len !== 1'b1) begin
            errors++;
            $display("FAIL nolast_err: err=%b want 1", err_len);
        end
        err_clr = 1'b1;
        @(negedge clk_p);
        err_clr = 1'b0;
        checks++;
        if (err_len !== 1'b0) begin
            errors++;
            $display("FAIL clr_pulse: err=%b want 0", err_len);
        end
        err_clr = 1'b1;
        send_vec(6, 3, 2, 1'b0);
        err_clr = 1'b0;
        checks++;
        if (err_len !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clr: err=%b want 1", err_len);
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        bit ok;
        repeat (210) @(negedge clk_p);
        send_vec(7, 51, -1, 1'b0);
        n0 = pulse_q.size();
        rst_n = 1'b1;
        repeat (2) @(negedge clk_p);
        checks++;
        if (out_valid_n !== 1'b1 || out_data !== '0) begin
            errors++;
            $display("FAIL mid_rst_out: valid_n=%b beat0=%h want 1/0",
                     out_valid_n, out_data[63:0]);
        end
        checks++;
        if (vec_cnt !== 16'd0 || err_len !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_cnt: vec_cnt=%0d err=%b want 0/0",
                     vec_cnt, err_len);
        end
        rst_n = 1'b0;
        rst_edge = cyc;
        repeat (5) @(negedge clk_p);
        checks++;
        if (pulse_q.size() !== n0) begin
            errors++;
            $display("FAIL mid_rst_pulse: pulses=%0d want %0d",
                     pulse_q.size(), n0);
        end
        send_vec(8, 96, 95, 1'b0);
        wait_pulse(n0, ok);
        if (ok) chk_pulse("after_rst", n0);
        checks++;
        if (vec_cnt !== 16'd1) begin
            errors++;
            $display("FAIL after_rst_cnt: got %0d want 1", vec_cnt);
        end
    endtask

    task automatic test_random;
        int n0;
        int base;
        bit ok;
        rst_n = 1'b1;
        repeat (2) @(negedge clk_p);
        rst_n = 1'b0;
        rst_edge = cyc;
        base = pulse_q.size();
        for (int v = 0; v < 10; v++) begin
            n0 = pulse_q.size();
            send_vec(0, 96, 95, 1'b1);
            wait_pulse(n0, ok);
            if (ok) chk_pulse("rand", n0);
        end
        repeat (3) @(negedge clk_p);
        checks++;
        if (vec_cnt !== 16'd10 || pulse_q.size() - base != 10) begin
            errors++;
            $display("FAIL rand_count: vec_cnt=%0d pulses=%0d want 10/10",
                     vec_cnt, pulse_q.size() - base);
        end
        checks++;
        if (long_pulses != 0) begin
            errors++;
            $display("FAIL rand_width: long=%0d want 0", long_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_early_last();
        test_len_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ln_vec_packer.md
Name: ln_vec_packer

Overview:
- Input staging stage directly upstream of the 768-element layernorm_nnlut.
- Accepts a narrow stream of signed 8-bit activations, BEAT_ELEMS per beat, over a valid/ready handshake.
- Packs VEC_LEN elements into one wide vector and presents it with a one-cycle active-low valid pulse.
- Spaces successive pulses by at least MIN_GAP cycles to match layernorm issue rate, since layernorm has no ready.

Parameters:
- ELEM_WIDTH, 8: bits per element.
- VEC_LEN, 768: elements per output vector.
- BEAT_ELEMS, 8: elements per input beat; VEC_LEN % BEAT_ELEMS == 0.
- MIN_GAP, 16: minimum number of cycles between successive out_valid_n pulses; must be ≥ 1.
- Derived: BEATS = VEC_LEN/BEAT_ELEMS = 96; CNT_W = clog2(BEATS).

Ports:
- clk_p  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-high (port name fixed by codebase convention).
- in_data  in  ELEM_WIDTH*BEAT_ELEMS  beat payload; element 0 in the LSBs.
- in_valid  in  1  beat valid.
- in_last  in  1  marks the final beat of a vector; qualified by in_valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- out_data  out  ELEM_WIDTH*VEC_LEN  packed vector for layernorm data.
- out_valid_n  out  1  active-low, one-cycle pulse.
- err_len  out  1  sticky framing error.
- err_clr  in  1  clears err_len.
- vec_cnt  out  16  count of vectors issued; wraps modulo 2^16.

Behaviour:
- Reset (rst_n=1 at an edge):
  - state=FILL, beat_cnt=0, gap_cnt=MIN_GAP (first issue not throttled).
  - out_data=0, out_valid_n=1, err_len=0, vec_cnt=0.
  - in_ready forced 0 while rst_n=1.
  - Reset mid-vector discards the partial vector; no pulse is issued.
- Storage: a fill buffer (BEATS x beat width) and a separate output register.
  - out_data stays stable from one issue until the next issue, including while the next vector fills.
- Packing: the beat accepted with beat_cnt=k is written to fill buffer bits [W*(k+1)-1 : W*k], where W = ELEM_WIDTH*BEAT_ELEMS.
- States:
  - FILL:
    - in_ready=1.
    - Each accepted beat increments beat_cnt.
    - Beat accepted with beat_cnt=BEATS-1 → ISSUE, beat_cnt←0.
    - If in_last=0 on that beat: err_len←1; the vector still completes.
    - Beat accepted with in_last=1 and beat_cnt<BEATS-1 (early last): err_len←1, the partial vector is dropped, beat_cnt←0, stay in FILL.
  - ISSUE:
    - in_ready=0.
    - If gap_cnt ≥ MIN_GAP: at the next edge out_data←fill buffer, out_valid_n←0, gap_cnt←1, vec_cnt←vec_cnt+1, state→FILL.
    - Otherwise wait in ISSUE.
- out_valid_n returns to 1 on the edge after it falls; it is exactly one cycle low.
- Latency: with the gap satisfied, the last beat is accepted at edge t, out_valid_n is 0 between edges t+1 and t+2, and in_ready is 1 again after edge t+1.
- Throughput: one vector per max(BEATS+1, MIN_GAP) cycles.
- gap_cnt: increments each cycle and saturates at MIN_GAP.
- Back-pressure: in_valid while in_ready=0 is not accepted. The source must hold its beat stable until it is accepted; the block does not check this.
- err_len:
  - Set as described under FILL.
  - err_clr=1 clears it; if a set and a clear occur in the same cycle, the set wins.
  - err_len does not block operation.
- in_last is ignored when in_valid=0.

Decomposition:
- Package ln_pkg holds:
  - LN_ELEM_WIDTH=8, LN_VEC_LEN=768, LN_BEAT_ELEMS=8, LN_MIN_GAP.
  - The state enum {FILL, ISSUE}.
  - The vector type ln_vec_t [6143:0].
- Sub-module issue_throttle (gap counter plus fire-enable output) is natural and reusable in front of nnlut_gelu_64 and the softmax.

Test Plan:
- Reset, then 96 beats with beat k holding element value (k*8+i) mod 256 and in_last on beat 95 → one out_valid_n low pulse at the 2nd edge after beat 95; out_data byte j = j mod 256; vec_cnt=1; err_len=0.
- Two back-to-back vectors with MIN_GAP=200 → the second pulse occurs exactly 200 cycles after the first; in_ready=0 in between after beat 95; the first out_data holds until the second pulse.
- in_last asserted on beat 40 → no pulse; err_len=1; the next 96-beat vector issues normally, with bytes 0..7 taken from that vector's beat 0.
- Beat 95 without in_last → pulse issued; err_len=1; err_clr pulse → err_len=0; err_clr coincident with a new error → err_len stays 1.
- rst_n asserted after beat 50 → no pulse; out_valid_n=1; out_data=0; vec_cnt=0; the following full vector is packed from beat 0 correctly.
- Random in_valid gaps (50% duty) over 10 vectors → 10 pulses, each exactly one cycle low; packed data matches the scoreboard; vec_cnt=10.
